apa102_spi_tx: RTL and testbench
================================

// Module: apa102_spi_tx
// PURPOSE
//  Serializer directly downstream of the LED colour sequencer: turns one RGB triple (or a
//  start frame) per ledstart request into a 32-bit APA102-style SPI frame on mosi/sck.
//  Reports busy so the sequencer paces requests. One frame per request, MSB first.
// PARAMETERS
//  CLK_DIV     3      sck half-period in CLK cycles (>=1); bit period = 2*CLK_DIV cycles
//  BRIGHTNESS  5'd31  global 5-bit brightness field placed in every LED frame
//  GAP_CYCLES  2      CLK cycles busy stays high after last sck fall (>=0)
// PORTS
//  CLK        in   1  system clock; all logic on posedge
//  myreset_n  in   1  synchronous reset, active low
//  red        in   8  red byte, sampled only on accepted request
//  green      in   8  green byte, sampled only on accepted request
//  blue       in   8  blue byte, sampled only on accepted request
//  stringend  in   1  sampled with request: 1 = send start frame (32 zeros), 0 = LED frame
//  ledstart   in   1  request; rising edge (0->1) starts a frame, level is ignored
//  mosi       out  1  serial data, valid while sck high
//  sck        out  1  serial clock, idles low
//  busy       out  1  high from cycle after accepted request until frame + gap done
//  frame_done out  1  one-cycle pulse on the cycle busy falls
// BEHAVIOUR
//  Reset (myreset_n=0 at posedge): mosi=0, sck=0, busy=0, frame_done=0, state=IDLE,
//   bit_cnt=0, div_cnt=0, shift=0, ledstart_q=1 (level held across reset release never fires).
//  ledstart_q <= ledstart every cycle; start = ledstart & ~ledstart_q.
//  LED frame word = {3'b111, BRIGHTNESS, blue, green, red}; start frame word = 32'h0.
//  FSM states IDLE, SHIFT_LO, SHIFT_HI, GAP:
//   IDLE: start at cycle T -> T+1: shift=word, mosi=word[31], sck=0, busy=1, bit_cnt=0,
//     div_cnt=0, state SHIFT_LO. No start -> hold; mosi=0, sck=0, busy=0.
//   SHIFT_LO: div_cnt counts 0..CLK_DIV-1; at CLK_DIV-1 -> sck=1, div_cnt=0, SHIFT_HI.
//   SHIFT_HI: at CLK_DIV-1 -> sck=0, div_cnt=0; if bit_cnt==31 -> mosi=0, GAP;
//     else shift<<=1, mosi=next bit, bit_cnt+=1, SHIFT_LO. mosi changes only with sck fall.
//   GAP: count GAP_CYCLES cycles (0 = leave at once), then busy=0, frame_done=1, IDLE.
//  Exactly 32 sck rising edges per frame; busy high for 64*CLK_DIV+GAP_CYCLES cycles
//   (194 at defaults). Next start may be accepted the cycle after busy falls.
//  Rising edge of ledstart while busy: dropped, not queued; ledstart_q still tracks.
//  red/green/blue/stringend changes while busy: no effect on frame in flight.
//  bit_cnt 5 bits, div_cnt sized for CLK_DIV-1 and GAP_CYCLES; no wrap beyond terminal values.
//  Reset mid-frame: next cycle all outputs at reset values, frame abandoned, no partial
//   sck edge after reset; ledstart_q=1 so a held request needs a fresh rising edge.
// TESTING
//  Reset with ledstart=1 held, release -> mosi=0, sck=0, busy=0, no frame until ledstart 0->1.
//  red=100,green=0,blue=20,stringend=0, 1-cycle ledstart -> bits on sck rise = 32'hFF140064,
//   exactly 32 rises, busy=1 for 194 cycles, one frame_done pulse, sck low after.
//  stringend=1 request -> 32 zero bits, 32 sck rises, busy 194 cycles.
//  ledstart held high 6 cycles, second 0->1 edge 50 cycles later (during busy) -> exactly one frame.
//  Assert myreset_n=0 after 10th sck rise -> next cycle sck=0, mosi=0, busy=0; no further edges.
//  Change red to 8'hAA at bit 5 of a red=8'h55 frame -> last byte shifted remains 8'h55.

Source files
------------

// File: rtl/apa102_spi_tx_if.sv
// Request/serial bundle between the LED colour sequencer (master) and the
// APA102 serializer (slave).
interface apa102_spi_tx_if;
  logic [7:0] red;
  logic [7:0] green;
  logic [7:0] blue;
  logic       stringend;
  logic       ledstart;
  logic       mosi;
  logic       sck;
  logic       busy;
  logic       frame_done;

  modport master (
    output red, green, blue, stringend, ledstart,
    input  mosi, sck, busy, frame_done
  );

  modport slave (
    input  red, green, blue, stringend, ledstart,
    output mosi, sck, busy, frame_done
  );
endinterface

// File: rtl/apa102_spi_tx.sv
// APA102 frame serializer: one 32-bit frame (LED word or all-zero start frame)
// per ledstart rising edge, MSB first, mode-0 style sck, all outputs registered.
module apa102_spi_tx #(
  parameter int         CLK_DIV    = 3,
  parameter logic [4:0] BRIGHTNESS = 5'd31,
  parameter int         GAP_CYCLES = 2
) (
  input  logic              CLK,
  input  logic              myreset_n,
  apa102_spi_tx_if.slave    bus
);

  localparam int CNT_MAX  = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int CNT_W    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] DIV_END = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_END = CNT_W'(GAP_LAST);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    GAP      = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      shift_q, shift_d;
  logic [4:0]       bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
  logic             mosi_q, mosi_d;
  logic             sck_q, sck_d;
  logic             busy_q, busy_d;
  logic             frame_done_q, frame_done_d;
  logic             ledstart_q, ledstart_d;
  logic             start_s;
  logic [31:0]      word_s;

  assign start_s = bus.ledstart & ~ledstart_q;
  assign word_s  = bus.stringend ? 32'h0000_0000
                                 : {3'b111, BRIGHTNESS, bus.blue, bus.green, bus.red};

  // Next-state and output computation for the frame FSM.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    div_cnt_d    = div_cnt_q;
    mosi_d       = mosi_q;
    sck_d        = sck_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    ledstart_d   = bus.ledstart;

    case (state_q)
      IDLE: begin
        if (start_s) begin
          shift_d   = word_s;
          mosi_d    = word_s[31];
          sck_d     = 1'b0;
          busy_d    = 1'b1;
          bit_cnt_d = 5'd0;
          div_cnt_d = {CNT_W{1'b0}};
          state_d   = SHIFT_LO;
        end else begin
          mosi_d = 1'b0;
          sck_d  = 1'b0;
          busy_d = 1'b0;
        end
      end
      SHIFT_LO: begin
        if (div_cnt_q == DIV_END) begin
          sck_d     = 1'b1;
          div_cnt_d = {CNT_W{1'b0}};
          state_d   = SHIFT_HI;
        end else begin
          div_cnt_d = div_cnt_q + CNT_W'(1);
        end
      end
      SHIFT_HI: begin
        if (div_cnt_q == DIV_END) begin
          sck_d     = 1'b0;
          div_cnt_d = {CNT_W{1'b0}};
          if (bit_cnt_q == 5'd31) begin
            mosi_d = 1'b0;
            // With no gap configured the frame ends on the last sck fall itself.
            if (GAP_CYCLES == 0) begin
              busy_d       = 1'b0;
              frame_done_d = 1'b1;
              state_d      = IDLE;
            end else begin
              state_d = GAP;
            end
          end else begin
            shift_d   = {shift_q[30:0], 1'b0};
            mosi_d    = shift_q[30];
            bit_cnt_d = bit_cnt_q + 5'd1;
            state_d   = SHIFT_LO;
          end
        end else begin
          div_cnt_d = div_cnt_q + CNT_W'(1);
        end
      end
      GAP: begin
        if (div_cnt_q == GAP_END) begin
          busy_d       = 1'b0;
          frame_done_d = 1'b1;
          div_cnt_d    = {CNT_W{1'b0}};
          state_d      = IDLE;
        end else begin
          div_cnt_d = div_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        mosi_d    = 1'b0;
        sck_d     = 1'b0;
        busy_d    = 1'b0;
        div_cnt_d = {CNT_W{1'b0}};
        bit_cnt_d = 5'd0;
      end
    endcase
  end

  // State register; ledstart_q resets high so a request held through reset never fires.
  always_ff @(posedge CLK) begin
    if (!myreset_n) begin
      state_q      <= IDLE;
      shift_q      <= 32'h0000_0000;
      bit_cnt_q    <= 5'd0;
      div_cnt_q    <= {CNT_W{1'b0}};
      mosi_q       <= 1'b0;
      sck_q        <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      ledstart_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      div_cnt_q    <= div_cnt_d;
      mosi_q       <= mosi_d;
      sck_q        <= sck_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      ledstart_q   <= ledstart_d;
    end
  end

  assign bus.mosi       = mosi_q;
  assign bus.sck        = sck_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_apa102_spi_tx.sv
// Directed bench for apa102_spi_tx: expected frame words go into a scoreboard
// queue at request time and are popped when 32 sck rises have been captured.
module tb_apa102_spi_tx;

  logic clk;
  logic rst_n;

  apa102_spi_tx_if bus ();

  apa102_spi_tx dut (
    .CLK       (clk),
    .myreset_n (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] sb[$];

  int          rises = 0;
  int          fd_cnt = 0;
  int          last_busy_len = 0;
  logic [31:0] last_word = 32'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input logic [7:0] r, input logic [7:0] g,
                                             input logic [7:0] b, input logic se);
    logic [31:0] w;
    if (se) w = 32'h0;
    else    w = {3'b111, 5'd31, b, g, r};
    return w;
  endfunction

  // Monitor: capture mosi on each sck rise, measure busy length, count frame_done.
  initial begin
    logic        prev_sck;
    logic [31:0] bits;
    int          nbits;
    int          busy_run;
    logic [31:0] exp_w;
    prev_sck = 1'b0;
    bits     = 32'h0;
    nbits    = 0;
    busy_run = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_sck = 1'b0;
        nbits    = 0;
        busy_run = 0;
      end else begin
        if (bus.sck && !prev_sck) begin
          rises++;
          bits = {bits[30:0], bus.mosi};
          nbits++;
          if (nbits == 32) begin
            nbits     = 0;
            last_word = bits;
            check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
              exp_w = sb.pop_front();
              check("frame_word", bits, exp_w);
            end
          end
        end
        if (bus.busy) begin
          busy_run++;
        end else if (busy_run != 0) begin
          last_busy_len = busy_run;
          busy_run      = 0;
        end
        if (bus.frame_done) begin
          fd_cnt++;
          check("done_with_busy_low", 32'(bus.busy), 32'd0);
        end
        prev_sck = bus.sck;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n;
    n = 0;
    while (fd_cnt < target && n < budget) begin
      tick();
      n++;
    end
    check("frame_timeout", 32'(fd_cnt >= target), 32'd1);
  endtask

  task automatic wait_rises(input int target, input int budget);
    int n;
    n = 0;
    while (rises < target && n < budget) begin
      tick();
      n++;
    end
    check("rise_timeout", 32'(rises >= target), 32'd1);
  endtask

  task automatic pulse_start();
    bus.ledstart = 1'b1;
    tick();
    check("busy_next_cycle", 32'(bus.busy), 32'd1);
    bus.ledstart = 1'b0;
  endtask

  initial begin
    int r0;
    int f0;
    rst_n         = 1'b0;
    bus.ledstart  = 1'b1;
    bus.red       = 8'h00;
    bus.green     = 8'h00;
    bus.blue      = 8'h00;
    bus.stringend = 1'b0;

    // Reset with ledstart held high, then release: no frame without a fresh edge.
    repeat (3) tick();
    check("rst_mosi", 32'(bus.mosi), 32'd0);
    check("rst_sck", 32'(bus.sck), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.frame_done), 32'd0);
    rst_n = 1'b1;
    repeat (20) tick();
    check("held_no_busy", 32'(bus.busy), 32'd0);
    check("held_no_rise", 32'(rises), 32'd0);
    bus.ledstart = 1'b0;
    tick();

    // LED frame red=100 green=0 blue=20.
    bus.red = 8'd100; bus.green = 8'd0; bus.blue = 8'd20; bus.stringend = 1'b0;
    sb.push_back(model_word(8'd100, 8'd0, 8'd20, 1'b0));
    r0 = rises; f0 = fd_cnt;
    pulse_start();
    wait_frames(f0 + 1, 400);
    tick();
    check("led_rises", 32'(rises - r0), 32'd32);
    check("led_busy_len", 32'(last_busy_len), 32'd194);
    check("led_done_cnt", 32'(fd_cnt - f0), 32'd1);
    check("led_sck_idle", 32'(bus.sck), 32'd0);
    check("led_mosi_idle", 32'(bus.mosi), 32'd0);
    check("led_sb_empty", 32'(sb.size()), 32'd0);

    // Start frame: 32 zero bits.
    bus.stringend = 1'b1;
    sb.push_back(model_word(bus.red, bus.green, bus.blue, 1'b1));
    r0 = rises; f0 = fd_cnt;
    pulse_start();
    wait_frames(f0 + 1, 400);
    tick();
    check("sf_rises", 32'(rises - r0), 32'd32);
    check("sf_busy_len", 32'(last_busy_len), 32'd194);
    check("sf_sb_empty", 32'(sb.size()), 32'd0);

    // Level held 6 cycles, second edge during busy is dropped.
    bus.stringend = 1'b0;
    bus.red = 8'hC3; bus.green = 8'h5A; bus.blue = 8'h81;
    sb.push_back(model_word(8'hC3, 8'h5A, 8'h81, 1'b0));
    r0 = rises; f0 = fd_cnt;
    bus.ledstart = 1'b1;
    repeat (6) tick();
    bus.ledstart = 1'b0;
    repeat (44) tick();
    check("dbl_busy_at_edge2", 32'(bus.busy), 32'd1);
    bus.ledstart = 1'b1;
    tick();
    bus.ledstart = 1'b0;
    wait_frames(f0 + 1, 400);
    repeat (250) tick();
    check("dbl_rises", 32'(rises - r0), 32'd32);
    check("dbl_done_cnt", 32'(fd_cnt - f0), 32'd1);
    check("dbl_sb_empty", 32'(sb.size()), 32'd0);

    // Reset after the 10th sck rise abandons the frame.
    bus.red = 8'hFF; bus.green = 8'hFF; bus.blue = 8'hFF;
    sb.push_back(model_word(8'hFF, 8'hFF, 8'hFF, 1'b0));
    r0 = rises; f0 = fd_cnt;
    bus.ledstart = 1'b1;
    tick();
    wait_rises(r0 + 10, 200);
    rst_n = 1'b0;
    sb.delete();
    tick();
    check("abort_sck", 32'(bus.sck), 32'd0);
    check("abort_mosi", 32'(bus.mosi), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (60) tick();
    check("abort_rises", 32'(rises - r0), 32'd10);
    check("abort_no_done", 32'(fd_cnt - f0), 32'd0);
    check("abort_held_idle", 32'(bus.busy), 32'd0);
    bus.ledstart = 1'b0;
    tick();

    // Inputs changing mid-frame do not disturb the frame in flight.
    bus.red = 8'h55; bus.green = 8'h12; bus.blue = 8'h34; bus.stringend = 1'b0;
    sb.push_back(model_word(8'h55, 8'h12, 8'h34, 1'b0));
    r0 = rises; f0 = fd_cnt;
    pulse_start();
    wait_rises(r0 + 5, 200);
    bus.red = 8'hAA; bus.green = 8'hFF; bus.blue = 8'hFF; bus.stringend = 1'b1;
    wait_frames(f0 + 1, 400);
    tick();
    check("chg_last_byte", {24'h0, last_word[7:0]}, 32'h55);
    check("chg_rises", 32'(rises - r0), 32'd32);
    check("chg_sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
